// File: rtl/lms_fir_param_if.sv
// Signal bundle for lms_fir_param: sample strobe, adaptation controls, filter results and coefficient readback.
// The master side drives samples and controls; the slave side is the filter itself.
interface lms_fir_param_if #(
   parameter int XW  = 12,
   parameter int DW  = 14,
   parameter int CW  = 16,
   parameter int L   = 16,
   parameter int MUW = 5
);
   localparam int AW = ($clog2(L) > 1) ? $clog2(L) : 1;
   localparam int YW = XW + CW + $clog2(L);

   logic                 in_valid;
   logic signed [XW-1:0] x_in;
   logic signed [DW-1:0] d_in;
   logic [MUW-1:0]       mu_in;
   logic                 mode;
   logic                 adapt_en;
   logic                 coef_clr;
   logic [AW-1:0]        coef_rd_addr;

   logic                 out_valid;
   logic signed [YW-1:0] y_out;
   logic signed [DW:0]   e_out;
   logic signed [CW-1:0] coef_rd_data;

   modport master (
      output in_valid, x_in, d_in, mu_in, mode, adapt_en, coef_clr, coef_rd_addr,
      input  out_valid, y_out, e_out, coef_rd_data
   );

   modport slave (
      input  in_valid, x_in, d_in, mu_in, mode, adapt_en, coef_clr, coef_rd_addr,
      output out_valid, y_out, e_out, coef_rd_data
   );
endinterface

// File: rtl/lms_fir_param.sv
// Parametrised LMS / sign-error-LMS adaptive FIR with freeze, coefficient clear and registered readback.
// Define LMS_FIR_SAT_EN to saturate the error and coefficient reductions instead of wrapping them.
module lms_fir_param #(
   parameter int XW   = 12,
   parameter int DW   = 14,
   parameter int CW   = 16,
   parameter int L    = 16,
   parameter int FRAC = 10,
   parameter int MUW  = 5
) (
   input logic            clk,
   input logic            reset,
   lms_fir_param_if.slave bus
);
   localparam int AW  = ($clog2(L) > 1) ? $clog2(L) : 1;
   localparam int YW  = XW + CW + $clog2(L);
   localparam int PW  = XW + CW;
   localparam int EW  = DW + 1;
   localparam int UW  = EW + XW;
`ifdef LMS_FIR_SAT_EN
   localparam int EFW = ((YW > DW) ? YW : DW) + 2;
   localparam int SW  = ((UW > CW) ? UW : CW) + 1;
`endif

   logic signed [XW-1:0] x_q [L];
   logic signed [XW-1:0] x_d [L];
   logic signed [CW-1:0] f_q [L];
   logic signed [CW-1:0] f_d [L];
   logic signed [DW-1:0] d_r_q, d_r_d;
   logic                 v1_q, v1_d;
   logic                 out_valid_q, out_valid_d;
   logic signed [YW-1:0] y_q, y_d;
   logic signed [EW-1:0] e_q, e_d;
   logic signed [CW-1:0] rd_q, rd_d;

   logic signed [YW-1:0] acc;
   logic signed [EW-1:0] e_red;
`ifdef LMS_FIR_SAT_EN
   logic signed [EFW-1:0] e_full;
`endif

   // Stage A: capture the new sample into the delay line and the desired value alongside it.
   always_comb begin
      for (int i = 0; i < L; i++) begin
         x_d[i] = x_q[i];
      end
      d_r_d = d_r_q;
      v1_d  = bus.in_valid;
      if (bus.in_valid) begin
         x_d[0] = bus.x_in;
         for (int i = 1; i < L; i++) begin
            x_d[i] = x_q[i-1];
         end
         d_r_d = bus.d_in;
      end
   end

   always_comb begin
      logic signed [PW-1:0] prod;
      acc  = '0;
      prod = '0;
      for (int i = 0; i < L; i++) begin
         prod = PW'(x_q[i]) * PW'(f_q[i]);
         acc  = acc + YW'(prod);
      end
`ifdef LMS_FIR_SAT_EN
      e_full = EFW'(d_r_q) - EFW'(acc >>> FRAC);
      if (!e_full[EFW-1] && (|e_full[EFW-2:DW])) begin
         e_red = {1'b0, {DW{1'b1}}};
      end else if (e_full[EFW-1] && !(&e_full[EFW-2:DW])) begin
         e_red = {1'b1, {DW{1'b0}}};
      end else begin
         e_red = e_full[DW:0];
      end
`else
      e_red = EW'(d_r_q) - EW'(acc >>> FRAC);
`endif
   end

   // Stage B: results only move when a sample is in flight, otherwise they hold.
   always_comb begin
      out_valid_d = v1_q;
      y_d         = y_q;
      e_d         = e_q;
      if (v1_q) begin
         y_d = acc;
         e_d = e_red;
      end
   end

   // Coefficient update reads the pre-shift delay line so the next sample sees the new taps immediately.
   always_comb begin
      logic signed [UW-1:0] sx;
`ifdef LMS_FIR_SAT_EN
      logic signed [SW-1:0] sum;
      sum = '0;
`endif
      sx = '0;
      for (int i = 0; i < L; i++) begin
         f_d[i] = f_q[i];
         sx     = '0;
         if (bus.coef_clr) begin
            f_d[i] = '0;
         end else if (v1_q && bus.adapt_en) begin
            if (bus.mode) begin
               if (e_red == '0) begin
                  sx = '0;
               end else if (e_red[EW-1]) begin
                  sx = -(UW'(x_q[i]));
               end else begin
                  sx = UW'(x_q[i]);
               end
            end else begin
               sx = UW'(e_red) * UW'(x_q[i]);
            end
`ifdef LMS_FIR_SAT_EN
            sum = SW'(f_q[i]) + SW'(sx >>> bus.mu_in);
            if (!sum[SW-1] && (|sum[SW-2:CW-1])) begin
               f_d[i] = {1'b0, {(CW-1){1'b1}}};
            end else if (sum[SW-1] && !(&sum[SW-2:CW-1])) begin
               f_d[i] = {1'b1, {(CW-1){1'b0}}};
            end else begin
               f_d[i] = sum[CW-1:0];
            end
`else
            f_d[i] = f_q[i] + CW'(sx >>> bus.mu_in);
`endif
         end
      end
   end

   // Addresses with no matching tap fall through to zero.
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < L; i++) begin
         if (bus.coef_rd_addr == AW'(i)) begin
            rd_d = f_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < L; i++) begin
            x_q[i] <= '0;
            f_q[i] <= '0;
         end
         d_r_q       <= '0;
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         e_q         <= '0;
         rd_q        <= '0;
      end else begin
         for (int i = 0; i < L; i++) begin
            x_q[i] <= x_d[i];
            f_q[i] <= f_d[i];
         end
         d_r_q       <= d_r_d;
         v1_q        <= v1_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         e_q         <= e_d;
         rd_q        <= rd_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.y_out        = y_q;
   assign bus.e_out        = e_q;
   assign bus.coef_rd_data = rd_q;
endmodule

// File: tb/tb_lms_fir_param.sv
// Self-checking bench for lms_fir_param: integer reference model compared every cycle plus directed literal checks.
// Honours LMS_FIR_SAT_EN the same way the design does.
module tb_lms_fir_param;
   localparam int XW   = 12;
   localparam int DW   = 14;
   localparam int CW   = 16;
   localparam int L    = 16;
   localparam int FRAC = 10;
   localparam int MUW  = 5;

   logic clk;
   logic reset;

   lms_fir_param_if #(.XW(XW), .DW(DW), .CW(CW), .L(L), .MUW(MUW)) bus ();

   lms_fir_param #(.XW(XW), .DW(DW), .CW(CW), .L(L), .FRAC(FRAC), .MUW(MUW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;
   bit chk_en     = 1'b0;

   longint mx [L];
   longint mf [L];
   bit     pend;
   longint pend_d;
   bit     exp_valid;
   longint exp_y, exp_e, exp_rd;
   longint m_acc, m_s;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run still active at %0t, required finish earlier", $time);
      $fatal(1, "[TB] timeout");
   end

   function automatic longint reduceTo(input longint v, input int bits);
      longint m, r, hi, lo;
      hi = (longint'(1) <<< (bits - 1)) - 1;
      lo = -(longint'(1) <<< (bits - 1));
`ifdef LMS_FIR_SAT_EN
      m = 0;
      r = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
      m = longint'(1) <<< bits;
      r = v % m;
      if (r < 0) r = r + m;
      if (r > hi) r = r - m;
`endif
      return r;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Reference model: one transaction-level step per clock edge, using plain integer arithmetic.
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < L; i++) begin
            mx[i] = 0;
            mf[i] = 0;
         end
         pend      = 1'b0;
         pend_d    = 0;
         exp_valid = 1'b0;
         exp_y     = 0;
         exp_e     = 0;
         exp_rd    = 0;
      end else begin
         exp_rd    = (int'(bus.coef_rd_addr) < L) ? mf[int'(bus.coef_rd_addr)] : 0;
         exp_valid = pend;
         if (pend) begin
            m_acc = 0;
            for (int i = 0; i < L; i++) m_acc = m_acc + mx[i] * mf[i];
            exp_y = m_acc;
            exp_e = reduceTo(pend_d - (m_acc >>> FRAC), DW + 1);
         end
         if (bus.coef_clr) begin
            for (int i = 0; i < L; i++) mf[i] = 0;
         end else if (pend && bus.adapt_en) begin
            for (int i = 0; i < L; i++) begin
               if (bus.mode) m_s = (exp_e > 0) ? mx[i] : ((exp_e < 0) ? -mx[i] : 0);
               else          m_s = exp_e * mx[i];
               mf[i] = reduceTo(mf[i] + (m_s >>> bus.mu_in), CW);
            end
         end
         if (bus.in_valid) begin
            for (int i = L - 1; i > 0; i--) mx[i] = mx[i-1];
            mx[0]  = longint'(bus.x_in);
            pend_d = longint'(bus.d_in);
            pend   = 1'b1;
         end else begin
            pend = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("out_valid", longint'(bus.out_valid), longint'(exp_valid));
         checkOutput("y_out", longint'(bus.y_out), exp_y);
         checkOutput("e_out", longint'(bus.e_out), exp_e);
         checkOutput("coef_rd_data", longint'(bus.coef_rd_data), exp_rd);
      end
   end

   task automatic applyStimulus(input bit v, input int x, input int d);
      @(negedge clk);
      bus.in_valid = v;
      bus.x_in     = XW'(x);
      bus.d_in     = DW'(d);
   endtask

   task automatic randomInputs();
      bus.in_valid = 1'($urandom);
      bus.x_in     = XW'($urandom);
      bus.d_in     = DW'($urandom);
      bus.mu_in    = MUW'($urandom);
      bus.mode     = 1'($urandom);
      bus.adapt_en = 1'($urandom);
      bus.coef_clr = 1'($urandom);
   endtask

   task automatic resetPulse();
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic setControl(input bit md, input int mu, input bit ad);
      bus.mode     = md;
      bus.mu_in    = MUW'(mu);
      bus.adapt_en = ad;
      bus.coef_clr = 1'b0;
   endtask

   initial begin
      reset            = 1'b0;
      bus.coef_rd_addr = '0;
      randomInputs();
      @(posedge clk);
      chk_en = 1'b1;

      repeat (2) begin
         @(negedge clk);
         randomInputs();
      end
      checkOutput("reset out_valid", longint'(bus.out_valid), 0);
      checkOutput("reset y_out", longint'(bus.y_out), 0);
      checkOutput("reset e_out", longint'(bus.e_out), 0);
      for (int a = 0; a < L; a++) begin
         bus.coef_rd_addr = 4'(a);
         @(negedge clk);
         randomInputs();
         checkOutput("reset coef readback", longint'(bus.coef_rd_data), 0);
      end

      // Freeze
      @(negedge clk);
      bus.in_valid     = 1'b0;
      bus.coef_rd_addr = '0;
      setControl(1'b0, 4, 1'b0);
      reset = 1'b1;
      applyStimulus(1'b1, 1024, 100);
      applyStimulus(1'b0, 0, 0);
      @(negedge clk);
      checkOutput("freeze out_valid", longint'(bus.out_valid), 1);
      checkOutput("freeze e_out", longint'(bus.e_out), 100);
      checkOutput("freeze y_out", longint'(bus.y_out), 0);
      checkOutput("freeze f0", longint'(bus.coef_rd_data), 0);

      // LMS update
      resetPulse();
      setControl(1'b0, 4, 1'b1);
      applyStimulus(1'b1, 256, 512);
      applyStimulus(1'b1, 256, 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("lms s1 e_out", longint'(bus.e_out), 512);
      @(negedge clk);
      checkOutput("lms s2 y_out", longint'(bus.y_out), 2097152);
      checkOutput("lms s2 e_out", longint'(bus.e_out), -2048);
      checkOutput("lms f0 after s1", longint'(bus.coef_rd_data), 8192);
      @(negedge clk);
      checkOutput("lms f0 after s2", longint'(bus.coef_rd_data), -24576);

      // Sign-error mode
      resetPulse();
      setControl(1'b1, 2, 1'b1);
      applyStimulus(1'b1, -400, 50);
      applyStimulus(1'b1, 0, 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("sign s1 e_out", longint'(bus.e_out), 50);
      @(negedge clk);
      checkOutput("sign s2 e_out", longint'(bus.e_out), 0);
      checkOutput("sign f0 after s1", longint'(bus.coef_rd_data), -100);
      @(negedge clk);
      checkOutput("sign f0 after zero error", longint'(bus.coef_rd_data), -100);

      // Coefficient reduction boundary
      resetPulse();
      setControl(1'b0, 0, 1'b1);
      applyStimulus(1'b1, 2047, 8191);
      applyStimulus(1'b0, 0, 0);
      @(negedge clk);
      checkOutput("sat e_out", longint'(bus.e_out), 8191);
      @(negedge clk);
`ifdef LMS_FIR_SAT_EN
      checkOutput("sat f0", longint'(bus.coef_rd_data), 32767);
`else
      checkOutput("wrap f0", longint'(bus.coef_rd_data), -10239);
`endif

      // Clear wins over a simultaneous update; the delay line survives it
      resetPulse();
      setControl(1'b0, 4, 1'b1);
      applyStimulus(1'b1, 256, 512);
      applyStimulus(1'b1, 256, 0);
      bus.coef_clr = 1'b1;
      applyStimulus(1'b0, 0, 0);
      bus.coef_clr = 1'b0;
      checkOutput("clr s1 e_out", longint'(bus.e_out), 512);
      @(negedge clk);
      checkOutput("clr s2 y_out", longint'(bus.y_out), 0);
      checkOutput("clr f0", longint'(bus.coef_rd_data), 0);
      applyStimulus(1'b1, 0, 64);
      applyStimulus(1'b1, 0, 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("clr s3 e_out", longint'(bus.e_out), 64);
      @(negedge clk);
      checkOutput("clr s4 y_out", longint'(bus.y_out), 262144);
      checkOutput("clr s4 e_out", longint'(bus.e_out), -256);

      // Reset one cycle after a sample: that sample never appears
      applyStimulus(1'b1, 100, 10);
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checkOutput("midreset out_valid", longint'(bus.out_valid), 0);
      @(negedge clk);
      checkOutput("midreset out_valid later", longint'(bus.out_valid), 0);
      repeat (3) @(negedge clk);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/lms_fir_param.md
# lms_fir_param

Parametrised LMS adaptive FIR filter: the next-generation replacement for the fixed 16-tap, 12-bit adaptive FIR in the a2dv2 detection path. It adds a valid handshake, a runtime LMS/sign-error-LMS mode, adaptation freeze, synchronous coefficient clear and coefficient readback. Optionally, coefficient and error arithmetic saturates. It sits between the ADC sample front end (`x_in`) and reference channel (`d_in`) and the downstream error/decision logic.

## Interface
- `XW`, 12: input sample width, signed.
- `DW`, 14: desired-signal width, signed.
- `CW`, 16: coefficient width, signed.
- `L`, 16: tap count, ≥2.
- `FRAC`, 10: fractional bits of coefficients; `y` is scaled by `>>> FRAC` before the error subtraction.
- `MUW`, 5: step-size shift width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `in_valid` in 1: sample strobe.
- `x_in` in XW: input sample, signed.
- `d_in` in DW: desired sample, signed.
- `mu_in` in MUW: step-size right-shift, 0..2^MUW-1.
- `mode` in 1: 0 = LMS, 1 = sign-error LMS.
- `adapt_en` in 1: 1 = coefficients update; 0 = frozen.
- `coef_clr` in 1: synchronous clear of all coefficients.
- `coef_rd_addr` in max(1,$clog2(L)): coefficient readback index.
- `out_valid` out 1: `y_out`/`e_out` update strobe.
- `y_out` out YW = XW+CW+$clog2(L): filter output, signed, full precision.
- `e_out` out DW+1: error, signed.
- `coef_rd_data` out CW: f[coef_rd_addr], registered.

## Operation
- While `reset` = 0 at a clock edge, these are cleared to 0: delay line x[0..L-1], coefficients f[0..L-1], d_r, v1, `out_valid`, `y_out`, `e_out` and `coef_rd_data`.
- Stage A, on an edge with `in_valid` = 1:
  - x[0] ← `x_in`, and x[i] ← x[i-1].
  - d_r ← `d_in`; v1 ← 1.
  - With `in_valid` = 0: no shift, and v1 ← 0.
- Stage B, on an edge with v1 = 1:
  - acc = Σ x[i]·f[i], exact at YW bits.
  - `y_out` ← acc.
  - e = d_r − (acc >>> FRAC), computed at full width and reduced to DW+1 bits.
  - `e_out` ← e; `out_valid` ← 1.
  - With v1 = 0: `out_valid` ← 0, and `y_out`/`e_out` hold.
- Update, on an edge with v1 = 1, `adapt_en` = 1 and `coef_clr` = 0, for every i:
  - mode 0: u_i = (e·x[i]) >>> `mu_in`, where e is the reduced `e_out` value.
  - mode 1: u_i = (sgn(e)·x[i]) >>> `mu_in`, where sgn is +1, −1, or 0 for e = 0.
  - f[i] ← f[i] + u_i, reduced to CW bits.
  - The update uses the x[i] values of stage B (pre-shift) and affects the next sample's acc.
- `coef_clr` = 1: all f ← 0. This takes priority over the update. The delay line, d_r and the pipeline are unaffected.
- Readback: `coef_rd_data` ← f[`coef_rd_addr`] every cycle, showing the pre-edge f. An address ≥ L returns 0.
- `mode`, `mu_in` and `adapt_en` are sampled at the stage-B edge and may change on any cycle.

## Timing
- Latency: `in_valid` in cycle n gives `out_valid` = 1 and the corresponding `y_out`/`e_out` in cycle n+2.
- Throughput: one sample per cycle. Back-to-back samples see the coefficients updated by the previous sample (no update delay).
- Gaps in `in_valid` produce equal gaps in `out_valid`. Coefficients hold during gaps.
- Reset asserted mid-stream: the in-flight sample is discarded and no `out_valid` is produced for it.
- `coef_rd_data` has a 1-cycle latency from `coef_rd_addr`.

## Configuration
- `LMS_FIR_SAT_EN` defined:
  - e reduction and the f[i] + u_i sum saturate to the signed range (e: ±2^DW bounds; f: −2^(CW−1) .. 2^(CW−1)−1).
- `LMS_FIR_SAT_EN` undefined:
  - both reductions are two's-complement truncation (wrap), bit-compatible with the previous generation's wrap behaviour.

## Test plan
All scenarios use the defaults (XW=12, DW=14, CW=16, L=16, FRAC=10).
- Reset: hold `reset` = 0 for 2 cycles with random inputs → all outputs 0 and `coef_rd_data` = 0 for every address.
- Freeze: `adapt_en` = 0, `x_in` = 1024, `d_in` = 100 → `e_out` = 100 two cycles later, `y_out` = 0, f[0] remains 0.
- LMS update: `mode` = 0, `mu_in` = 4.
  - Sample 1: x = 256, d = 512 → `e_out` = 512 and f[0] = 8192.
  - Sample 2: x = 256, d = 0 → `y_out` = 2097152 and `e_out` = −2048.
- Sign mode: `mode` = 1, `mu_in` = 2, x = −400, d = 50 → `e_out` = 50 and f[0] = −100. Then d = 0 with e = 0 → f unchanged.
- Saturation: `mu_in` = 0, x = 2047, d = 8191, single sample →
  - with `LMS_FIR_SAT_EN`: f[0] = 32767;
  - without: f[0] = −10239.
- Clear/priority: assert `coef_clr` in the same cycle as an update → all f = 0 next cycle and the delay line is intact. Then reset mid-stream one cycle after `in_valid` → no `out_valid` for that sample.
